// File: rtl/aes_inv_round_ctrl_if.sv
// Handshake and key-store bus of the iterative AES inverse round controller.
interface aes_inv_round_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    modport slave (
        input  in_valid, in_data, rk_data, flush, out_ready,
        output in_ready, rk_addr, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, rk_data, flush, out_ready,
        input  in_ready, rk_addr, out_valid, out_data, busy
    );
endinterface

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES inverse cipher: one round per clock, round keys fetched
// combinationally from an external key store addressed by rk_addr.
module aes_inv_round_ctrl #(
    parameter int unsigned NR = 10
) (
    input logic                 clk,
    input logic                 rst_n,
    aes_inv_round_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_e;

    localparam logic [3:0] NR_ADDR = 4'(NR);

    fsm_e         fsm_q, fsm_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] out_data_q, out_data_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         out_valid_q, out_valid_d;
    logic [3:0]   rk_addr_w;
    logic [127:0] sub_w, addk_w, mix_w;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (square-and-multiply); 0 maps to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r, sq;
        r  = 8'h01;
        sq = a;
        for (int unsigned k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] t;
        t = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned i = 0; i < 16; i++)
            o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 32] = {
                gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
            };
        end
        return o;
    endfunction

    // Shared by the middle rounds and the final round.
    assign sub_w  = inv_sub_bytes(inv_shift_rows(blk_q));
    assign addk_w = sub_w ^ bus.rk_data;
    assign mix_w  = inv_mix_columns(addk_w);

    always_comb begin
        fsm_d       = fsm_q;
        blk_d       = blk_q;
        rnd_d       = rnd_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        rk_addr_w   = NR_ADDR;
        unique case (fsm_q)
            IDLE: begin
                if (bus.in_valid && !bus.flush) begin
                    blk_d = bus.in_data ^ bus.rk_data;
                    rnd_d = NR_ADDR - 4'd1;
                    fsm_d = ROUND;
                end
            end
            ROUND: begin
                rk_addr_w = rnd_q;
                blk_d     = mix_w;
                rnd_d     = rnd_q - 4'd1;
                if (rnd_q == 4'd1) fsm_d = FINAL;
            end
            FINAL: begin
                rk_addr_w   = '0;
                out_data_d  = addk_w;
                out_valid_d = 1'b1;
                fsm_d       = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
        // Abort keeps the previously delivered plaintext on out_data.
        if (bus.flush && fsm_q != IDLE) begin
            fsm_d       = IDLE;
            out_valid_d = 1'b0;
            out_data_d  = out_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            blk_q       <= '0;
            rnd_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            blk_q       <= blk_d;
            rnd_q       <= rnd_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (fsm_q == IDLE);
    assign bus.busy      = (fsm_q != IDLE);
    assign bus.rk_addr   = rk_addr_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: forward-AES reference model with random
// round keys, plus FIPS-197 C.1 and handshake/flush/reset scenarios.
module tb_aes_inv_round_ctrl;

    localparam int unsigned NR = 10;
    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_inv_round_ctrl_if bus();

    aes_inv_round_ctrl #(.NR(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [127:0] rk_mem [0:15];
    assign bus.rk_data = rk_mem[bus.rk_addr];

    logic [7:0]   sb [0:255];
    int unsigned  n_checks = 0;
    int unsigned  n_errors = 0;
    int unsigned  cyc = 0;
    logic [127:0] last_pt = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    // Forward S-box: brute-force field inverse, then the affine map.
    task automatic build_sbox();
        logic [7:0] inv, x;
        for (int unsigned v = 0; v < 256; v++) begin
            x = 8'(v);
            inv = '0;
            for (int unsigned y = 1; y < 256; y++)
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] v;
        v = pt ^ rk_mem[0];
        for (int unsigned r = 1; r <= NR; r++) begin
            for (int unsigned i = 0; i < 16; i++) s[i] = sb[v[127 - 8*i -: 8]];
            for (int unsigned row = 0; row < 4; row++)
                for (int unsigned col = 0; col < 4; col++)
                    t[row + 4*col] = s[row + 4*((col + row) % 4)];
            for (int unsigned col = 0; col < 4; col++) begin
                a0 = t[4*col]; a1 = t[4*col+1]; a2 = t[4*col+2]; a3 = t[4*col+3];
                if (r < NR) begin
                    s[4*col]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*col+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*col+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*col+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*col] = a0; s[4*col+1] = a1; s[4*col+2] = a2; s[4*col+3] = a3;
                end
            end
            for (int unsigned i = 0; i < 16; i++) v[127 - 8*i -: 8] = s[i];
            v = v ^ rk_mem[r];
        end
        return v;
    endfunction

    task automatic load_c1_keys();
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] key;
        key = 128'h000102030405060708090a0b0c0d0e0f;
        rc  = 8'h01;
        for (int unsigned i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int unsigned i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int unsigned r = 0; r <= NR; r++)
            rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic load_random_keys();
        for (int unsigned r = 0; r <= NR; r++) rk_mem[r] = rand128();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Offers a ciphertext in IDLE; returns one cycle after the accepting edge.
    task automatic start_op(input logic [127:0] ct, input bit keep_valid);
        int unsigned n;
        n = 0;
        while (!bus.in_ready && n < 64) begin
            tick();
            n++;
        end
        check("in_ready_wait", bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = ct;
        check("idle_rk_addr", bus.rk_addr, NR);
        check("idle_busy", bus.busy, 1'b0);
        tick();
        if (!keep_valid) bus.in_valid = 1'b0;
    endtask

    // Called in cycle T+1; follows the operation through the out_ready handshake.
    task automatic expect_result(input logic [127:0] exp, input int unsigned hold, input bit early);
        for (int unsigned k = 1; k <= NR; k++) begin
            check("rk_addr_trace", bus.rk_addr, NR - k);
            check("no_early_valid", bus.out_valid, 1'b0);
            check("busy_in_op", bus.busy, 1'b1);
            check("in_ready_in_op", bus.in_ready, 1'b0);
            if (early && k == NR) bus.out_ready = 1'b1;
            tick();
        end
        check("valid_at_latency", bus.out_valid, 1'b1);
        check("plaintext", bus.out_data, exp);
        if (!early) begin
            for (int unsigned h = 0; h < hold; h++) begin
                tick();
                check("hold_valid", bus.out_valid, 1'b1);
                check("hold_data", bus.out_data, exp);
                check("hold_in_ready", bus.in_ready, 1'b0);
            end
            bus.out_ready = 1'b1;
        end
        tick();
        check("valid_drop", bus.out_valid, 1'b0);
        check("ready_after_hs", bus.in_ready, 1'b1);
        check("data_after_hs", bus.out_data, exp);
        if (!early) bus.out_ready = 1'b0;
        last_pt = exp;
    endtask

    task automatic watch_no_valid(input string tag, input int unsigned n);
        bit saw;
        saw = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            tick();
            if (bus.out_valid) saw = 1'b1;
        end
        check(tag, saw, 1'b0);
    endtask

    initial begin
        logic [127:0] pt, pt2, ct, ct2;
        int unsigned  n;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        for (int unsigned i = 0; i < 16; i++) rk_mem[i] = '0;
        build_sbox();

        #2;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, '0);
        check("rst_rk_addr", bus.rk_addr, NR);
        #5 rst_n = 1'b1;
        tick();

        // FIPS-197 C.1
        load_c1_keys();
        start_op(C1_CT, 1'b0);
        expect_result(C1_PT, 2, 1'b0);

        // flush beats in_valid in IDLE
        bus.in_valid = 1'b1;
        bus.in_data  = C1_CT;
        bus.flush    = 1'b1;
        tick();
        check("idle_flush_busy", bus.busy, 1'b0);
        check("idle_flush_rk", bus.rk_addr, NR);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;

        // random round keys and plaintexts against the forward model
        for (int unsigned i = 0; i < 12; i++) begin
            load_random_keys();
            pt = rand128();
            ct = aes_encrypt(pt);
            n = $urandom_range(0, 2);
            for (int unsigned g = 0; g < n; g++) tick();
            if ($urandom_range(0, 1) == 1) begin
                start_op(ct, 1'b0);
                expect_result(pt, 0, 1'b1);
                bus.out_ready = 1'b0;
            end else begin
                start_op(ct, 1'b0);
                expect_result(pt, $urandom_range(0, 3), 1'b0);
            end
        end

        // backpressure with in_valid held high
        load_random_keys();
        pt  = rand128();
        pt2 = rand128();
        ct  = aes_encrypt(pt);
        ct2 = aes_encrypt(pt2);
        start_op(ct, 1'b1);
        bus.in_data = ct2;
        expect_result(pt, 20, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        expect_result(pt2, 0, 1'b0);

        // back-to-back with out_ready tied high
        pt  = rand128();
        pt2 = rand128();
        ct  = aes_encrypt(pt);
        ct2 = aes_encrypt(pt2);
        bus.out_ready = 1'b1;
        start_op(ct, 1'b1);
        bus.in_data = ct2;
        expect_result(pt, 0, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        expect_result(pt2, 0, 1'b1);
        bus.out_ready = 1'b0;

        // flush while rnd == 5, then a clean C.1 run
        load_c1_keys();
        start_op(C1_CT, 1'b0);
        n = 0;
        while (bus.rk_addr != 4'd5 && n < NR) begin
            tick();
            n++;
        end
        check("flush_at_rnd5", bus.rk_addr, 4'd5);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_busy", bus.busy, 1'b0);
        check("flush_in_ready", bus.in_ready, 1'b1);
        check("flush_out_valid", bus.out_valid, 1'b0);
        check("flush_rk_addr", bus.rk_addr, NR);
        watch_no_valid("flush_no_pulse", 15);
        start_op(C1_CT, 1'b0);
        expect_result(C1_PT, 1, 1'b0);

        // flush in the final round keeps the old out_data
        load_random_keys();
        pt = rand128();
        ct = aes_encrypt(pt);
        start_op(ct, 1'b0);
        n = 0;
        while (bus.rk_addr != 4'd0 && n < NR + 2) begin
            tick();
            n++;
        end
        check("final_reached", bus.rk_addr, 4'd0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("final_flush_valid", bus.out_valid, 1'b0);
        check("final_flush_data", bus.out_data, last_pt);
        check("final_flush_busy", bus.busy, 1'b0);
        watch_no_valid("final_flush_no_pulse", 15);

        // asynchronous reset between edges in ROUND
        load_c1_keys();
        start_op(C1_CT, 1'b0);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 1'b0);
        check("arst_busy", bus.busy, 1'b0);
        check("arst_in_ready", bus.in_ready, 1'b1);
        check("arst_rk_addr", bus.rk_addr, NR);
        check("arst_out_data", bus.out_data, '0);
        #2 rst_n = 1'b1;
        watch_no_valid("arst_no_pulse", 15);
        start_op(C1_CT, 1'b0);
        expect_result(C1_PT, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
